shared_vec_seq: RTL and testbench
=================================

// Module: shared_vec_seq
// PURPOSE
//  Upstream operand sequencer for the shared two-mode combinational unit.
//  - Drives all 32 {m,a,b,c,d} input vectors in ascending order.
//  - Holds each vector for a programmable settle time, then samples {s1,s0}.
//  - Folds every sample into a rotate-XOR signature for on-board self-check.
//  - Replaces the timed-delay stimulus with synthesizable, clocked control.
// PARAMETERS
//  HOLD_CYCLES  1   cycles each vector is driven before its sample cycle (>=1)
//  SIG_W        16  signature register width (>=4)
// PORTS
//  clk           in   1      single clock, all logic rising-edge
//  rst           in   1      synchronous, active-high reset
//  start         in   1      begin a sweep; honoured only in IDLE or DONE
//  pause         in   1      freeze sequencing while high
//  a,b,c,d       out  1 each operand bits to shared unit (a = MSB)
//  m             out  1      mode bit to shared unit
//  s1,s0         in   1 each result bits from shared unit
//  busy          out  1      high in DRIVE/SAMPLE
//  done          out  1      high in DONE until next start or rst
//  vec_idx       out  5      current vector index, equals {m,a,b,c,d}
//  sample_valid  out  1      one-cycle pulse; sig just updated
//  sig           out  SIG_W  running signature
// BEHAVIOUR
//  Reset (rst=1 at edge): state IDLE; all outputs 0; hold counter 0.
//   rst overrides everything, including a sweep in progress.
//  Vector mapping: {m,a,b,c,d} = vec_idx.
//   - Indices 0..15: m=0, abcd counts 0000..1111.
//   - Indices 16..31: m=1, abcd counts again.
//  FSM:
//   - IDLE:   start -> DRIVE; vec_idx=0, sig=0, hold=0, done=0.
//   - DRIVE:  hold increments when pause=0;
//             hold==HOLD_CYCLES-1 and pause=0 -> SAMPLE.
//   - SAMPLE: if pause=0, capture sig; then
//             vec_idx==31 -> DONE, else vec_idx+1, hold=0 -> DRIVE.
//             if pause=1, stay in SAMPLE, no capture.
//   - DONE:   done=1, busy=0; outputs hold the last vector;
//             start -> same actions as from IDLE.
//  Signature update on capture:
//   sig <= {sig[SIG_W-2:0],sig[SIG_W-1]} ^ {{SIG_W-2{1'b0}},s1,s0}
//  sample_valid = registered capture strobe: high in the cycle after capture.
//  Timing, start sampled at edge t, pause=0:
//   - busy=1 and vector 0 driven from t+1.
//   - Each vector lasts HOLD_CYCLES+1 cycles.
//   - Final capture at edge t+32*(HOLD_CYCLES+1); done=1 immediately after it.
//  Operand outputs are registers; they change only when leaving SAMPLE or on restart.
//  start while busy: ignored. start and pause together in IDLE: enter DRIVE, then freeze.
//  pause high in IDLE/DONE: no effect.
// STRUCTURE
//  - Package shared_seq_pkg: state localparams IDLE/DRIVE/SAMPLE/DONE (2-bit),
//    NUM_VEC=32, LAST_IDX=5'd31.
//  - Sub-module shared_sig_reg (params SIG_W; ports clk, rst, clr, en, din[1:0], sig).
//  - Top holds FSM, hold counter, index register, and the strobe flop.
// TESTING (shared unit stubbed as needed)
//  1 Reset: rst high 2 cycles mid-sweep -> next cycle all outputs 0, state IDLE.
//  2 Sweep, HOLD_CYCLES=1, s1s0 tied 00, start at t:
//    vec_idx steps 0..31 every 2 cycles; m=0 for idx<16, m=1 for idx>=16;
//    done=1 after edge t+64; sig=0x0000; exactly 32 sample_valid pulses.
//  3 Signature, s1s0 tied 01, SIG_W=16:
//    sig=0xFFFF after 16th pulse, 0xFFFE after 17th, 0x0000 at done.
//  4 Pause 5 cycles during vector 7 (DRIVE and again in SAMPLE):
//    vec_idx stays 7, no pulse while paused; done is late by exactly the paused cycles.
//  5 start pulsed while busy -> ignored, no index reset;
//    start in DONE -> sig cleared, vec_idx=0, busy=1 on next cycle, full sweep repeats.
//  6 HOLD_CYCLES=3: each vector held 4 cycles; s1s0 sampled only in the 4th cycle.

Source files
------------

// File: rtl/shared_seq_pkg.sv
// Shared definitions for the operand sequencer that feeds the shared
// two-mode combinational unit.
//   state_t  : 2-bit FSM state type
//   IDLE/DRIVE/SAMPLE/DONE : FSM state encodings
//   NUM_VEC  : number of {m,a,b,c,d} vectors in one sweep
//   LAST_IDX : index of the final vector of a sweep
package shared_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t DRIVE  = 2'd1;
  localparam state_t SAMPLE = 2'd2;
  localparam state_t DONE   = 2'd3;

  localparam int         NUM_VEC  = 32;
  localparam logic [4:0] LAST_IDX = 5'd31;

endpackage

// File: rtl/shared_sig_reg.sv
// Rotate-XOR signature register. Every enabled cycle folds a 2-bit
// sample into the running signature: rotate left by one, then XOR the
// sample into the two low bits.
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset, clears the signature
//   clr  in   synchronous clear at the start of a sweep (wins over en)
//   en   in   fold din into the signature this cycle
//   din  in   [1:0] sample {s1,s0}
//   sig  out  [SIG_W-1:0] current signature
module shared_sig_reg #(
  parameter int SIG_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  function automatic logic [SIG_W-1:0] sig_fold(input logic [SIG_W-1:0] cur,
                                                input logic [1:0]       smp);
    return {cur[SIG_W-2:0], cur[SIG_W-1]} ^ {{(SIG_W-2){1'b0}}, smp};
  endfunction

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = sig_fold(sig_q, din);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/shared_vec_seq.sv
// Operand sequencer for the shared two-mode combinational unit.
// Walks all 32 {m,a,b,c,d} vectors in ascending order, holds each one for
// HOLD_CYCLES settle cycles, samples {s1,s0} in the following cycle and
// folds the sample into a rotate-XOR signature.
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   start        in   begin a sweep (only from IDLE or DONE)
//   pause        in   freeze sequencing while high (DRIVE/SAMPLE only)
//   a,b,c,d,m    out  registered operand bits, {m,a,b,c,d} = vec_idx
//   s1,s0        in   result bits from the shared unit
//   busy         out  high while a sweep is in progress
//   done         out  high after the last sample until restart or reset
//   vec_idx      out  [4:0] current vector index
//   sample_valid out  one-cycle pulse in the cycle after each capture
//   sig          out  [SIG_W-1:0] running signature
module shared_vec_seq
  import shared_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter int SIG_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             m,
  input  logic             s1,
  input  logic             s0,
  output logic             busy,
  output logic             done,
  output logic [4:0]       vec_idx,
  output logic             sample_valid,
  output logic [SIG_W-1:0] sig
);

  // The hold counter runs 0..HOLD_CYCLES; the extra code point is the
  // value it reaches on the transition into SAMPLE.
  localparam int               HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q,  hold_d;
  logic [4:0]        idx_q,   idx_d;
  logic              strobe_q, strobe_d;
  logic              sig_clr;
  logic              sig_en;

  // State register plus the datapath registers it steers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      idx_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
    end
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    sig_clr = 1'b0;
    sig_en  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        // pause is deliberately ignored here; a start with pause high
        // still enters DRIVE and then freezes there.
        if (start) begin
          state_d = DRIVE;
          idx_d   = '0;
          hold_d  = '0;
          sig_clr = 1'b1;
        end
      end
      DRIVE: begin
        if (!pause) begin
          hold_d = hold_q + 1'b1;
          if (hold_q == HOLD_LAST) begin
            state_d = SAMPLE;
          end
        end
      end
      SAMPLE: begin
        if (!pause) begin
          sig_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            // Operands keep the last vector while in DONE.
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 5'd1;
            hold_d  = '0;
            state_d = DRIVE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    strobe_d = sig_en;
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    busy = (state_q == DRIVE) || (state_q == SAMPLE);
    done = (state_q == DONE);
  end

  shared_sig_reg #(
    .SIG_W (SIG_W)
  ) u_sig (
    .clk (clk),
    .rst (rst),
    .clr (sig_clr),
    .en  (sig_en),
    .din ({s1, s0}),
    .sig (sig)
  );

  assign {m, a, b, c, d} = idx_q;
  assign vec_idx         = idx_q;
  assign sample_valid    = strobe_q;

endmodule

// File: tb/tb_shared_vec_seq.sv
// Bench for shared_vec_seq: one instance with HOLD_CYCLES=1 and one with
// HOLD_CYCLES=3. A sweep-level model (elapsed active cycles -> vector index
// and capture points) is compared against both instances every cycle, and
// directed checks pin timing and signature values worked out by hand.
module tb_shared_vec_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_i, start_i, pause_i, s1_i, s0_i;
  logic [1:0] a_o, b_o, c_o, d_o, m_o, busy_o, done_o, sv_o;
  logic [4:0]  vidx0, vidx1;
  logic [15:0] sig0, sig1;

  shared_vec_seq #(.HOLD_CYCLES(1), .SIG_W(16)) u_dut0 (
    .clk(clk), .rst(rst_i[0]), .start(start_i[0]), .pause(pause_i[0]),
    .a(a_o[0]), .b(b_o[0]), .c(c_o[0]), .d(d_o[0]), .m(m_o[0]),
    .s1(s1_i[0]), .s0(s0_i[0]), .busy(busy_o[0]), .done(done_o[0]),
    .vec_idx(vidx0), .sample_valid(sv_o[0]), .sig(sig0)
  );

  shared_vec_seq #(.HOLD_CYCLES(3), .SIG_W(16)) u_dut1 (
    .clk(clk), .rst(rst_i[1]), .start(start_i[1]), .pause(pause_i[1]),
    .a(a_o[1]), .b(b_o[1]), .c(c_o[1]), .d(d_o[1]), .m(m_o[1]),
    .s1(s1_i[1]), .s0(s0_i[1]), .busy(busy_o[1]), .done(done_o[1]),
    .vec_idx(vidx1), .sample_valid(sv_o[1]), .sig(sig1)
  );

  // Model state: a sweep is just a count of un-paused cycles since start.
  bit          m_run  [2];
  bit          m_done [2];
  bit          m_val  [2];
  int          m_n    [2];
  int          m_idx  [2];
  logic [15:0] m_sig  [2];

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  int          pulses [2];
  logic [15:0] sig_hist [2][34];

  function automatic int hold_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [15:0] fold(input logic [15:0] v, input logic [1:0] s);
    return {v[14:0], v[15]} ^ {14'd0, s};
  endfunction

  task automatic model_step(input int i);
    int per;
    per = hold_of(i) + 1;
    if (rst_i[i]) begin
      m_run[i] = 0; m_done[i] = 0; m_val[i] = 0;
      m_n[i] = 0; m_idx[i] = 0; m_sig[i] = '0;
    end else begin
      m_val[i] = 0;
      if (!m_run[i]) begin
        if (start_i[i]) begin
          m_run[i] = 1; m_done[i] = 0; m_n[i] = 0; m_idx[i] = 0; m_sig[i] = '0;
        end
      end else if (!pause_i[i]) begin
        if ((m_n[i] % per) == per - 1) begin
          m_sig[i] = fold(m_sig[i], {s1_i[i], s0_i[i]});
          m_val[i] = 1;
          if ((m_n[i] / per) == 31) begin
            m_run[i] = 0; m_done[i] = 1;
          end
        end
        m_n[i]++;
        if (m_run[i]) m_idx[i] = m_n[i] / per;
      end
    end
  endtask

  task automatic compare(input int i);
    logic [4:0]  vi, vec;
    logic [15:0] sg;
    vi  = (i == 0) ? vidx0 : vidx1;
    sg  = (i == 0) ? sig0 : sig1;
    vec = {m_o[i], a_o[i], b_o[i], c_o[i], d_o[i]};
    tests++;
    if (busy_o[i] !== m_run[i] || done_o[i] !== m_done[i] ||
        vi !== 5'(m_idx[i]) || vec !== 5'(m_idx[i]) ||
        sv_o[i] !== m_val[i] || sg !== m_sig[i]) begin
      fails++;
      $display("FAIL cycle_cmp inst%0d cyc%0d: got busy=%b done=%b idx=%0d vec=%0d sv=%b sig=%h; want busy=%b done=%b idx=%0d sv=%b sig=%h",
               i, cyc, busy_o[i], done_o[i], vi, vec, sv_o[i], sg,
               m_run[i], m_done[i], m_idx[i], m_val[i], m_sig[i]);
    end
    if (sv_o[i] === 1'b1) begin
      pulses[i]++;
      if (pulses[i] < 34) sig_hist[i][pulses[i]] = sg;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    cyc++;
    compare(0);
    compare(1);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic start_sweep(input int i, output int t);
    start_i[i] = 1'b1;
    tick();
    start_i[i] = 1'b0;
    t = cyc;
  endtask

  task automatic wait_done(input int i, input int limit, input string name, output int e);
    e = -1;
    for (int k = 0; k < limit; k++) begin
      tick();
      if (done_o[i] === 1'b1) begin
        e = cyc;
        break;
      end
    end
    if (e < 0) begin
      tests++;
      fails++;
      $display("FAIL %s: done not seen within %0d cycles", name, limit);
    end
  endtask

  initial begin
    int t, e, p, ib, cnt5;
    rst_i = 2'b11; start_i = '0; pause_i = '0; s1_i = '0; s0_i = '0;
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_done[i] = 0; m_val[i] = 0;
      m_n[i] = 0; m_idx[i] = 0; m_sig[i] = '0; pulses[i] = 0;
    end
    tick();
    tick();
    rst_i = 2'b00;
    tick();
    check("reset_state", {16'd0, busy_o, done_o, sv_o, 5'(vidx0 | vidx1), 5'd0}, 32'd0);
    check("reset_sig", {sig1, sig0}, 32'd0);

    // Reset in the middle of a sweep, with samples that make sig non-zero.
    s1_i[0] = 1'b1; s0_i[0] = 1'b1;
    start_sweep(0, t);
    repeat (9) tick();
    check("mid_busy", 32'(busy_o[0]), 32'd1);
    check("mid_sig_nonzero", 32'(sig0 != 16'd0), 32'd1);
    rst_i[0] = 1'b1;
    tick();
    tick();
    rst_i[0] = 1'b0;
    check("rst_mid_outputs",
          {8'd0, busy_o[0], done_o[0], sv_o[0], m_o[0], a_o[0], b_o[0], c_o[0], d_o[0], vidx0, 3'd0},
          32'd0);
    check("rst_mid_sig", 32'(sig0), 32'd0);

    // Full sweep, HOLD_CYCLES=1, samples tied 00.
    s1_i[0] = 1'b0; s0_i[0] = 1'b0;
    pulses[0] = 0;
    start_sweep(0, t);
    wait_done(0, 200, "sweep_h1_00", e);
    check("done_edge_h1", 32'(e - t), 32'd64);
    check("sig_h1_00", 32'(sig0), 32'h0000);
    check("pulses_h1_00", 32'(pulses[0]), 32'd32);
    check("done_last_vec", 32'({m_o[0], a_o[0], b_o[0], c_o[0], d_o[0]}), 32'd31);

    // Restart from DONE with samples tied 01.
    s1_i[0] = 1'b0; s0_i[0] = 1'b1;
    pulses[0] = 0;
    start_sweep(0, t);
    check("restart_state", {16'd0, 7'd0, busy_o[0], done_o[0], 2'd0, vidx0}, {16'd0, 7'd0, 1'b1, 1'b0, 2'd0, 5'd0});
    check("restart_sig", 32'(sig0), 32'd0);
    wait_done(0, 200, "sweep_h1_01", e);
    check("sig_pulse16", 32'(sig_hist[0][16]), 32'hFFFF);
    check("sig_pulse17", 32'(sig_hist[0][17]), 32'hFFFE);
    check("sig_h1_01_done", 32'(sig0), 32'h0000);
    check("pulses_h1_01", 32'(pulses[0]), 32'd32);

    // Pause 5 cycles in DRIVE and 5 in SAMPLE of vector 7.
    s1_i[0] = 1'b1; s0_i[0] = 1'b0;
    pulses[0] = 0;
    start_sweep(0, t);
    for (int k = 0; k < 40 && vidx0 != 5'd7; k++) tick();
    check("reach_vec7", 32'(vidx0), 32'd7);
    p = pulses[0];
    pause_i[0] = 1'b1;
    repeat (5) begin
      tick();
      check("pause_drive_idx", 32'(vidx0), 32'd7);
    end
    check("pause_drive_pulses", 32'(pulses[0]), 32'(p));
    pause_i[0] = 1'b0;
    tick();
    pause_i[0] = 1'b1;
    repeat (5) begin
      tick();
      check("pause_sample_idx", 32'(vidx0), 32'd7);
    end
    check("pause_sample_pulses", 32'(pulses[0]), 32'(p));
    pause_i[0] = 1'b0;
    wait_done(0, 200, "sweep_pause", e);
    check("done_edge_paused", 32'(e - t), 32'd74);
    check("pulses_paused", 32'(pulses[0]), 32'd32);

    // start while busy is ignored.
    s1_i[0] = 1'b1; s0_i[0] = 1'b1;
    pulses[0] = 0;
    start_sweep(0, t);
    repeat (20) tick();
    ib = int'(vidx0);
    start_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0;
    check("start_busy_idx_kept", 32'(int'(vidx0) >= ib && ib > 0), 32'd1);
    wait_done(0, 200, "sweep_start_busy", e);
    check("done_edge_start_busy", 32'(e - t), 32'd64);
    check("pulses_start_busy", 32'(pulses[0]), 32'd32);

    // start together with pause from IDLE: enter DRIVE, then freeze.
    rst_i[0] = 1'b1;
    tick();
    rst_i[0] = 1'b0;
    tick();
    pause_i[0] = 1'b1;
    start_sweep(0, t);
    check("start_pause_busy", 32'(busy_o[0]), 32'd1);
    repeat (3) tick();
    check("start_pause_idx", 32'(vidx0), 32'd0);
    pause_i[0] = 1'b0;
    wait_done(0, 200, "sweep_start_pause", e);
    check("done_edge_start_pause", 32'(e - t), 32'd67);

    // HOLD_CYCLES=3: 01 only on the sample edge of each vector, 11 otherwise.
    pulses[1] = 0;
    cnt5 = 0;
    start_sweep(1, t);
    e = -1;
    for (int k = 0; k < 300; k++) begin
      if (((cyc + 1 - t) % 4) == 0) begin
        s1_i[1] = 1'b0; s0_i[1] = 1'b1;
      end else begin
        s1_i[1] = 1'b1; s0_i[1] = 1'b1;
      end
      tick();
      if (busy_o[1] === 1'b1 && vidx1 == 5'd5) cnt5++;
      if (done_o[1] === 1'b1) begin
        e = cyc;
        break;
      end
    end
    check("done_edge_h3", 32'(e - t), 32'd128);
    check("vec5_len_h3", 32'(cnt5), 32'd4);
    check("sig_h3_pulse16", 32'(sig_hist[1][16]), 32'hFFFF);
    check("sig_h3_pulse17", 32'(sig_hist[1][17]), 32'hFFFE);
    check("sig_h3_done", 32'(sig1), 32'h0000);
    check("pulses_h3", 32'(pulses[1]), 32'd32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
